// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline hazard logic.
// Slot entries track in-flight register writes after ID.
package mips_pkg;

  localparam int MAX_AW = 8;

  typedef logic [2:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REGFILE = 3'd0;

  typedef struct packed {
    logic              valid;
    logic [MAX_AW-1:0] dst;
    logic              reg_wr;
    logic              is_load;
  } slot_t;

endpackage

// File: rtl/hazard_match.sv
// Youngest-producer priority encoder for one source operand.
// Yields the forward select and a load-use stall request.
module hazard_match
  import mips_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1
) (
  input  slot_t [DEPTH-1:0] slots,
  input  logic              use_src,
  input  logic [MAX_AW-1:0] src,
  output fwd_sel_t          sel,
  output logic              load_use
);

  // Scan oldest to youngest so the lowest index overrides.
  always_comb begin
    sel      = FWD_REGFILE;
    load_use = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (use_src && src != '0 &&
          slots[k].valid && slots[k].reg_wr &&
          slots[k].dst == src) begin
        sel = (k + 1 <= DEPTH - 1) ? fwd_sel_t'(k + 1)
                                   : FWD_REGFILE;
        load_use = slots[k].is_load && (k < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/mips_hazard_unit.sv
// Forwarding and load-use interlock unit for the pipelined MIPS core.
// Tracks in-flight writers and registers operand selects into EX.
module mips_hazard_unit
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_AW-1:0]         id_rs,
  input  logic [REG_AW-1:0]         id_rt,
  input  logic                      id_use_rs,
  input  logic                      id_use_rt,
  input  logic [REG_AW-1:0]         id_dst,
  input  logic                      id_reg_wr,
  input  logic                      id_is_load,
  input  logic [DATA_W-1:0]         id_rdata_a,
  input  logic [DATA_W-1:0]         id_rdata_b,
  input  logic                      flush,
  input  logic [(DEPTH-1)*DATA_W-1:0] slot_result,
  output logic                      stall,
  output logic                      ex_valid,
  output logic [2:0]                ex_fwd_a,
  output logic [2:0]                ex_fwd_b,
  output logic [DATA_W-1:0]         ex_op_a,
  output logic [DATA_W-1:0]         ex_op_b,
  output logic [CNT_W-1:0]          stall_cnt
);

  slot_t [DEPTH-1:0] slots;
  slot_t             id_slot;
  fwd_sel_t          sel_a;
  fwd_sel_t          sel_b;
  logic              lu_a;
  logic              lu_b;
  logic              issue;
  logic [DATA_W-1:0] rd_a_q;
  logic [DATA_W-1:0] rd_b_q;

  hazard_match #(
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT)
  ) u_match_rs (
    .slots    (slots),
    .use_src  (id_use_rs),
    .src      (MAX_AW'(id_rs)),
    .sel      (sel_a),
    .load_use (lu_a)
  );

  hazard_match #(
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT)
  ) u_match_rt (
    .slots    (slots),
    .use_src  (id_use_rt),
    .src      (MAX_AW'(id_rt)),
    .sel      (sel_b),
    .load_use (lu_b)
  );

  // Flush kills the ID instruction, so it can never stall.
  assign stall = id_valid & ~flush & (lu_a | lu_b);
  assign issue = id_valid & ~flush & ~stall;

  assign id_slot = '{
    valid:   1'b1,
    dst:     MAX_AW'(id_dst),
    reg_wr:  id_reg_wr,
    is_load: id_is_load
  };

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots <= '0;
    end else begin
      slots[0] <= issue ? id_slot : '0;
      for (int k = 1; k < DEPTH; k++)
        slots[k] <= slots[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_fwd_a <= FWD_REGFILE;
      ex_fwd_b <= FWD_REGFILE;
      rd_a_q   <= '0;
      rd_b_q   <= '0;
    end else begin
      ex_valid <= issue;
      ex_fwd_a <= issue ? sel_a : FWD_REGFILE;
      ex_fwd_b <= issue ? sel_b : FWD_REGFILE;
      rd_a_q   <= issue ? id_rdata_a : '0;
      rd_b_q   <= issue ? id_rdata_b : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

  // Select k picks slot k's result, packed from slot 1 upward.
  always_comb begin
    ex_op_a = rd_a_q;
    ex_op_b = rd_b_q;
    for (int k = 1; k < DEPTH; k++) begin
      if (ex_fwd_a == fwd_sel_t'(k))
        ex_op_a = slot_result[(k-1)*DATA_W +: DATA_W];
      if (ex_fwd_b == fwd_sel_t'(k))
        ex_op_b = slot_result[(k-1)*DATA_W +: DATA_W];
    end
  end

endmodule

// File: doc/mips_hazard_unit.md
Name: mips_hazard_unit

Overview:
- Parametrised forwarding and interlock unit for the pipelined MIPS core.
- Tracks in-flight register writes in a DEPTH-slot shift register (slot 0 = EX, 1 = MEM, 2 = WB by default).
- Registers forwarding selects and operands into the EX stage.
- Stalls ID on load-use hazards instead of relying on a software load delay slot.
- Sits between the ID-stage decode and the ALU operand inputs; replaces the ad-hoc ex/mem forward flags in the control block.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width (register 0 is hardwired zero)
- DEPTH, 3, tracked slots after ID (EX..WB); legal range 2..8
- LOAD_LAT, 1, slots after EX before load data is forwardable; must satisfy LOAD_LAT+1 <= DEPTH-1
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_AW  source A address
- id_rt  in  REG_AW  source B address
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_dst  in  REG_AW  destination register
- id_reg_wr  in  1  instruction writes id_dst
- id_is_load  in  1  instruction is LW
- id_rdata_a  in  DATA_W  regfile read data A
- id_rdata_b  in  DATA_W  regfile read data B
- flush  in  1  kill the ID instruction (taken branch/jump redirect)
- slot_result  in  (DEPTH-1)*DATA_W  packed result bus for slots 1..DEPTH-1
- stall  out  1  hold PC and IF/ID register this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_fwd_a  out  3  EX operand A source: 0 = regfile, k = slot k
- ex_fwd_b  out  3  EX operand B source, same encoding
- ex_op_a  out  DATA_W  resolved operand A
- ex_op_b  out  DATA_W  resolved operand B
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Slot entry fields: valid, dst, reg_wr, is_load. Each clock, slot k moves to k+1; slot DEPTH-1 retires.
- Slot 0 load rule:
  - gets the ID instruction when id_valid & !stall & !flush;
  - otherwise gets a bubble (valid=0).
- Producer match for source X (rs or rt):
  - requires id_use_X, slot valid, reg_wr, dst == X, and X != 0;
  - the youngest (lowest-index) matching slot wins.
- Forward select: producer in slot j gives sel = j+1 if j+1 <= DEPTH-1, else 0. The regfile writes in the first half of the cycle, so a retiring write is visible.
- Load-use stall: stall = id_valid & !flush & (any winning match on a load with j+1 < LOAD_LAT+1).
  - A load match that is not the youngest match never stalls.
  - Default parameters give exactly a one-cycle bubble for LW followed by a dependent instruction.
- Stall and flush together: flush wins, stall = 0, bubble inserted.
- EX registers, written on every clock:
  - ex_valid and ex_fwd_* take the slot-0 load value; bubbles force sel = 0.
  - the latched rdata is captured alongside.
- Operand mux: ex_op_X = (sel == 0) ? latched rdata : slot_result[sel]. The mux is combinational from the registers and slot_result.
- Latency: one cycle from ID inputs to ex_* outputs. stall is combinational from ID inputs and slot state.
- stall_cnt increments on each stall cycle and saturates at all-ones.
- Reset (asynchronous, mid-operation included) values:
  - all slots invalid;
  - stall = 0, ex_valid = 0, ex_fwd_a = ex_fwd_b = 0, ex_op_a = ex_op_b = 0;
  - stall_cnt = 0.
  - The first clock after deassertion issues normally.

Decomposition:
- Package mips_pkg holds:
  - slot_t struct {valid, dst, reg_wr, is_load};
  - fwd_sel_t (3-bit);
  - FWD_REGFILE = 0.
- One sub-module, hazard_match: combinational youngest-match priority encoder over the slot array for one source. It is instantiated twice (rs, rt).

Test Plan:
- ADDI r1 then NOR r2,r1,r1 back-to-back, slot1 result 0x00000005 -> ex_fwd_a = 1, ex_op_a = 0x5, stall never asserted.
- LW r3 then SUBU r4,r3,r5 -> stall high exactly one cycle, bubble enters EX (ex_valid = 0), then ex_fwd_a = 2 with ex_op_a = slot_result[2]; stall_cnt = 1.
- Producer three instructions earlier (DEPTH = 3) -> ex_fwd = 0 and ex_op = regfile data.
- Writes to r0 with a matching reader -> no forward, no stall.
- Two in-flight writers to r6 in slot0 (ADDI) and slot1 (LW) -> youngest wins: sel = 1, no stall.
- LW hazard with flush asserted the same cycle -> stall = 0, bubble issued.
- rst pulsed mid-stall -> all outputs 0 asynchronously.
- 2^CNT_W+3 stall cycles with CNT_W = 4 -> stall_cnt holds 0xF.
